// File: rtl/tcp_payload_pkg.sv
// Shared types and sizing for the TCP payload descriptor rings.
// Both the send-side and receive-side queues use these definitions.
package tcp_payload_pkg;

    localparam int FLOW_CNT     = 8;
    localparam int WIN_SIZE     = 16;
    localparam int ENTRY_ADDR_W = 32;
    localparam int ENTRY_LEN_W  = 16;
    localparam int FLOW_ID_W    = $clog2(FLOW_CNT);
    localparam int IDX_W        = $clog2(WIN_SIZE);
    localparam int RING_ELS     = FLOW_CNT * WIN_SIZE;
    localparam int RING_ADDR_W  = FLOW_ID_W + IDX_W;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] pkt_payload_addr;
        logic [ENTRY_LEN_W-1:0]  pkt_payload_len;
    } payload_buf_entry;

    localparam int ENTRY_W = $bits(payload_buf_entry);

    // Slots to retire on an ack.
    // The count is clamped to the sent-but-unacked span, so unsent entries survive an over-ack.
    function automatic logic [IDX_W-1:0] ack_advance(
        input logic [IDX_W-1:0] head,
        input logic [IDX_W-1:0] send,
        input logic [IDX_W-1:0] cnt
    );
        logic [IDX_W-1:0] inflight;
        inflight = send - head;
        return (cnt < inflight) ? cnt : inflight;
    endfunction

    function automatic logic [RING_ADDR_W-1:0] ring_addr(
        input logic [FLOW_ID_W-1:0] flowid,
        input logic [IDX_W-1:0]     idx
    );
        return {flowid, idx};
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sync.sv
// One-write, one-read synchronous RAM.
// Reads return the old contents on a same-address write; only the read register is reset.
module bsg_mem_1r1w_sync #(
    parameter int width_p       = 48,
    parameter int els_p         = 128,
    parameter int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] r_data_q;

    // NOTE: storage arrays get no reset; clearing them would force a flop array in place of a RAM.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data_q <= '0;
        end else if (r_v_i) begin
            r_data_q <= mem_q[r_addr_i];
        end
    end

    assign r_data_o = r_data_q;

endmodule

// File: rtl/send_payload_ptr_table.sv
// Per-flow ring pointer table: flop array with two combinational read ports.
// It has one write port and a clear port, and clear wins over write to the same flow.
module send_payload_ptr_table
    import tcp_payload_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLOW_ID_W-1:0] rd0_addr,
    output logic [IDX_W-1:0]     rd0_data,
    input  logic [FLOW_ID_W-1:0] rd1_addr,
    output logic [IDX_W-1:0]     rd1_data,
    input  logic                 wr_val,
    input  logic [FLOW_ID_W-1:0] wr_addr,
    input  logic [IDX_W-1:0]     wr_data,
    input  logic                 clr_val,
    input  logic [FLOW_ID_W-1:0] clr_addr
);

    logic [IDX_W-1:0] ptr_q [FLOW_CNT];
    logic [IDX_W-1:0] ptr_d [FLOW_CNT];

    always_comb begin
        // NOTE: start from the held value so the conditional updates below cannot infer latches.
        ptr_d = ptr_q;
        if (wr_val) begin
            ptr_d[wr_addr] = wr_data;
        end
        if (clr_val) begin
            ptr_d[clr_addr] = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FLOW_CNT; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign rd0_data = ptr_q[rd0_addr];
    assign rd1_data = ptr_q[rd1_addr];

endmodule

// File: rtl/send_payload_queues.sv
// Per-flow transmit descriptor rings with head (oldest unacked), send (next to transmit) and tail (next free) pointers.
// The app enqueues descriptors, the send engine pops unsent ones, and ack processing retires sent ones.
module send_payload_queues
    import tcp_payload_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    new_flow_val,
    input  logic [FLOW_ID_W-1:0]    new_flow_id,

    input  logic                    enq_req_val,
    input  logic [FLOW_ID_W-1:0]    enq_req_flowid,
    input  logic [ENTRY_ADDR_W-1:0] enq_req_addr,
    input  logic [ENTRY_LEN_W-1:0]  enq_req_len,
    output logic                    enq_resp_val,
    output logic                    enq_resp_full,

    input  logic                    send_req_val,
    input  logic [FLOW_ID_W-1:0]    send_req_flowid,
    output logic                    send_resp_val,
    output logic                    send_resp_empty,
    output logic [ENTRY_ADDR_W-1:0] send_resp_addr,
    output logic [ENTRY_LEN_W-1:0]  send_resp_len,

    input  logic                    ack_val,
    input  logic [FLOW_ID_W-1:0]    ack_flowid,
    input  logic [IDX_W-1:0]        ack_cnt
);

    logic [IDX_W-1:0] enq_tail, enq_head;
    logic [IDX_W-1:0] snd_send, snd_tail;
    logic [IDX_W-1:0] ack_head, ack_send;

    logic enq_blocked, snd_blocked, ack_blocked;
    logic enq_full, snd_empty;
    logic enq_do, snd_do, ack_do;
    logic [IDX_W-1:0] ack_new_head;

    logic enq_resp_val_q,   enq_resp_val_d;
    logic enq_resp_full_q,  enq_resp_full_d;
    logic send_resp_val_q,  send_resp_val_d;
    logic send_resp_empty_q, send_resp_empty_d;

    payload_buf_entry wr_entry, rd_entry;

    // Every port decides from pre-update pointers; all three tables commit together at the edge.
    always_comb begin
        enq_blocked  = new_flow_val && (new_flow_id == enq_req_flowid);
        snd_blocked  = new_flow_val && (new_flow_id == send_req_flowid);
        ack_blocked  = new_flow_val && (new_flow_id == ack_flowid);

        enq_full     = (enq_tail + 1'b1) == enq_head;
        snd_empty    = snd_send == snd_tail;

        enq_do       = enq_req_val  && !enq_blocked && !enq_full;
        snd_do       = send_req_val && !snd_blocked && !snd_empty;
        ack_do       = ack_val      && !ack_blocked;
        ack_new_head = ack_head + ack_advance(ack_head, ack_send, ack_cnt);

        enq_resp_val_d    = enq_req_val;
        enq_resp_full_d   = enq_req_val && (enq_blocked || enq_full);
        send_resp_val_d   = send_req_val;
        send_resp_empty_d = send_req_val && (snd_blocked || snd_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enq_resp_val_q    <= 1'b0;
            enq_resp_full_q   <= 1'b0;
            send_resp_val_q   <= 1'b0;
            send_resp_empty_q <= 1'b0;
        end else begin
            enq_resp_val_q    <= enq_resp_val_d;
            enq_resp_full_q   <= enq_resp_full_d;
            send_resp_val_q   <= send_resp_val_d;
            send_resp_empty_q <= send_resp_empty_d;
        end
    end

    send_payload_ptr_table u_head_table (
        .clk      (clk),
        .rst      (rst),
        .rd0_addr (enq_req_flowid),
        .rd0_data (enq_head),
        .rd1_addr (ack_flowid),
        .rd1_data (ack_head),
        .wr_val   (ack_do),
        .wr_addr  (ack_flowid),
        .wr_data  (ack_new_head),
        .clr_val  (new_flow_val),
        .clr_addr (new_flow_id)
    );

    send_payload_ptr_table u_send_table (
        .clk      (clk),
        .rst      (rst),
        .rd0_addr (send_req_flowid),
        .rd0_data (snd_send),
        .rd1_addr (ack_flowid),
        .rd1_data (ack_send),
        .wr_val   (snd_do),
        .wr_addr  (send_req_flowid),
        .wr_data  (snd_send + 1'b1),
        .clr_val  (new_flow_val),
        .clr_addr (new_flow_id)
    );

    send_payload_ptr_table u_tail_table (
        .clk      (clk),
        .rst      (rst),
        .rd0_addr (enq_req_flowid),
        .rd0_data (enq_tail),
        .rd1_addr (send_req_flowid),
        .rd1_data (snd_tail),
        .wr_val   (enq_do),
        .wr_addr  (enq_req_flowid),
        .wr_data  (enq_tail + 1'b1),
        .clr_val  (new_flow_val),
        .clr_addr (new_flow_id)
    );

    assign wr_entry = '{pkt_payload_addr: enq_req_addr, pkt_payload_len: enq_req_len};

    bsg_mem_1r1w_sync #(
        .width_p (ENTRY_W),
        .els_p   (RING_ELS)
    ) u_ring (
        .clk_i    (clk),
        .reset_i  (rst),
        .w_v_i    (enq_do),
        .w_addr_i (ring_addr(enq_req_flowid, enq_tail)),
        .w_data_i (wr_entry),
        .r_v_i    (snd_do),
        .r_addr_i (ring_addr(send_req_flowid, snd_send)),
        .r_data_o (rd_entry)
    );

    assign enq_resp_val    = enq_resp_val_q;
    assign enq_resp_full   = enq_resp_full_q;
    assign send_resp_val   = send_resp_val_q;
    assign send_resp_empty = send_resp_empty_q;
    assign send_resp_addr  = rd_entry.pkt_payload_addr;
    assign send_resp_len   = rd_entry.pkt_payload_len;

endmodule

// File: tb/tb_send_payload_queues.sv
// Bench for send_payload_queues: directed scenarios plus randomized traffic.
// Expected responses come from a per-flow queue model of the descriptor rings.
module tb_send_payload_queues;
    import tcp_payload_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    new_flow_val = 1'b0;
    logic [FLOW_ID_W-1:0]    new_flow_id = '0;
    logic                    enq_req_val = 1'b0;
    logic [FLOW_ID_W-1:0]    enq_req_flowid = '0;
    logic [ENTRY_ADDR_W-1:0] enq_req_addr = '0;
    logic [ENTRY_LEN_W-1:0]  enq_req_len = '0;
    logic                    enq_resp_val, enq_resp_full;
    logic                    send_req_val = 1'b0;
    logic [FLOW_ID_W-1:0]    send_req_flowid = '0;
    logic                    send_resp_val, send_resp_empty;
    logic [ENTRY_ADDR_W-1:0] send_resp_addr;
    logic [ENTRY_LEN_W-1:0]  send_resp_len;
    logic                    ack_val = 1'b0;
    logic [FLOW_ID_W-1:0]    ack_flowid = '0;
    logic [IDX_W-1:0]        ack_cnt = '0;

    always #5 clk = ~clk;

    send_payload_queues dut (
        .clk             (clk),
        .rst             (rst),
        .new_flow_val    (new_flow_val),
        .new_flow_id     (new_flow_id),
        .enq_req_val     (enq_req_val),
        .enq_req_flowid  (enq_req_flowid),
        .enq_req_addr    (enq_req_addr),
        .enq_req_len     (enq_req_len),
        .enq_resp_val    (enq_resp_val),
        .enq_resp_full   (enq_resp_full),
        .send_req_val    (send_req_val),
        .send_req_flowid (send_req_flowid),
        .send_resp_val   (send_resp_val),
        .send_resp_empty (send_resp_empty),
        .send_resp_addr  (send_resp_addr),
        .send_resp_len   (send_resp_len),
        .ack_val         (ack_val),
        .ack_flowid      (ack_flowid),
        .ack_cnt         (ack_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per flow, the unsent descriptors in order and the count of sent-but-unacked ones.
    logic [47:0] unsent_q [FLOW_CNT][$];
    int          sent_cnt [FLOW_CNT];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear_all();
        for (int f = 0; f < FLOW_CNT; f++) begin
            unsent_q[f].delete();
            sent_cnt[f] = 0;
        end
    endtask

    // Drives one request cycle starting just after a rising edge, then checks responses #1 after the next edge.
    task automatic drive_cycle(
        input logic nf_v, input logic [FLOW_ID_W-1:0] nf_id,
        input logic e_v,  input logic [FLOW_ID_W-1:0] e_f,
        input logic [ENTRY_ADDR_W-1:0] e_a, input logic [ENTRY_LEN_W-1:0] e_l,
        input logic s_v,  input logic [FLOW_ID_W-1:0] s_f,
        input logic a_v,  input logic [FLOW_ID_W-1:0] a_f, input logic [IDX_W-1:0] a_c
    );
        logic        exp_full, exp_empty, a_blk;
        logic [47:0] exp_desc;
        int          adv;

        new_flow_val = nf_v; new_flow_id = nf_id;
        enq_req_val = e_v; enq_req_flowid = e_f; enq_req_addr = e_a; enq_req_len = e_l;
        send_req_val = s_v; send_req_flowid = s_f;
        ack_val = a_v; ack_flowid = a_f; ack_cnt = a_c;

        exp_full = 1'b0;
        if (e_v)
            exp_full = (nf_v && nf_id == e_f) ||
                       (sent_cnt[e_f] + unsent_q[e_f].size() == WIN_SIZE - 1);
        exp_empty = 1'b0;
        exp_desc  = '0;
        if (s_v) begin
            exp_empty = (nf_v && nf_id == s_f) || (unsent_q[s_f].size() == 0);
            if (!exp_empty) exp_desc = unsent_q[s_f][0];
        end
        a_blk = nf_v && nf_id == a_f;
        adv = (int'(a_c) < sent_cnt[a_f]) ? int'(a_c) : sent_cnt[a_f];

        if (nf_v) begin
            unsent_q[nf_id].delete();
            sent_cnt[nf_id] = 0;
        end
        if (e_v && !exp_full) unsent_q[e_f].push_back({e_a, e_l});
        if (a_v && !a_blk) sent_cnt[a_f] -= adv;
        if (s_v && !exp_empty) begin
            void'(unsent_q[s_f].pop_front());
            sent_cnt[s_f]++;
        end

        @(posedge clk);
        #1;
        new_flow_val = 1'b0; enq_req_val = 1'b0; send_req_val = 1'b0; ack_val = 1'b0;

        check("enq_resp_val", enq_resp_val, e_v);
        if (e_v) check("enq_resp_full", enq_resp_full, exp_full);
        check("send_resp_val", send_resp_val, s_v);
        if (s_v) begin
            check("send_resp_empty", send_resp_empty, exp_empty);
            if (!exp_empty) begin
                check("send_resp_addr", send_resp_addr, exp_desc[47:16]);
                check("send_resp_len", send_resp_len, exp_desc[15:0]);
            end
        end
    endtask

    task automatic init_flow(input logic [FLOW_ID_W-1:0] f);
        drive_cycle(1'b1, f, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic enq(input logic [FLOW_ID_W-1:0] f, input logic [31:0] a, input logic [15:0] l);
        drive_cycle(1'b0, '0, 1'b1, f, a, l, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic snd(input logic [FLOW_ID_W-1:0] f);
        drive_cycle(1'b0, '0, 1'b0, '0, '0, '0, 1'b1, f, 1'b0, '0, '0);
    endtask

    task automatic ack(input logic [FLOW_ID_W-1:0] f, input logic [IDX_W-1:0] c);
        drive_cycle(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, f, c);
    endtask

    initial begin
        model_clear_all();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_enq_val", enq_resp_val, 1'b0);
        check("rst_enq_full", enq_resp_full, 1'b0);
        check("rst_send_val", send_resp_val, 1'b0);
        check("rst_send_empty", send_resp_empty, 1'b0);
        check("rst_send_addr", send_resp_addr, '0);
        check("rst_send_len", send_resp_len, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: basic enqueue/send order
        init_flow(3'd2);
        enq(3'd2, 32'h1000, 16'd64);
        enq(3'd2, 32'h2000, 16'd128);
        snd(3'd2);
        check("t1_addr0", send_resp_addr, 32'h1000);
        check("t1_len0", send_resp_len, 16'd64);
        snd(3'd2);
        check("t1_addr1", send_resp_addr, 32'h2000);
        check("t1_len1", send_resp_len, 16'd128);
        snd(3'd2);
        check("t1_empty", send_resp_empty, 1'b1);

        // 2: fill to capacity, then free one slot
        init_flow(3'd1);
        for (int i = 0; i < WIN_SIZE; i++) enq(3'd1, 32'h100 + i, 16'(i));
        check("t2_full16", enq_resp_full, 1'b1);
        snd(3'd1);
        ack(3'd1, 4'd1);
        enq(3'd1, 32'hABCD, 16'd7);
        check("t2_after_ack", enq_resp_full, 1'b0);

        // 3: wrap across idx 15 -> 0 in steady state
        init_flow(3'd3);
        enq(3'd3, 32'h3000, 16'd1);
        enq(3'd3, 32'h3001, 16'd2);
        for (int i = 0; i < 20; i++)
            drive_cycle(1'b0, '0, 1'b1, 3'd3, 32'h3100 + i, 16'(i + 3),
                        1'b1, 3'd3, 1'b1, 3'd3, 4'd1);

        // 4: same-cycle enqueue+send on an empty flow
        init_flow(3'd4);
        drive_cycle(1'b0, '0, 1'b1, 3'd4, 32'h4000, 16'd44, 1'b1, 3'd4, 1'b0, '0, '0);
        check("t4_empty", send_resp_empty, 1'b1);
        snd(3'd4);
        check("t4_addr", send_resp_addr, 32'h4000);

        // 5: over-ack clamps to the send pointer
        init_flow(3'd5);
        enq(3'd5, 32'h5001, 16'd1);
        enq(3'd5, 32'h5002, 16'd2);
        enq(3'd5, 32'h5003, 16'd3);
        snd(3'd5);
        ack(3'd5, 4'd5);
        snd(3'd5);
        check("t5_addr", send_resp_addr, 32'h5002);
        for (int i = 0; i < 14; i++) enq(3'd5, 32'h5100 + i, 16'(i));
        check("t5_full", enq_resp_full, 1'b1);

        // Randomized traffic over a few flows to create collisions
        for (int i = 0; i < 1500; i++) begin
            logic [FLOW_ID_W-1:0] nf_id, e_f, s_f, a_f;
            nf_id = FLOW_ID_W'($urandom_range(0, 3));
            e_f   = FLOW_ID_W'($urandom_range(0, 3));
            s_f   = FLOW_ID_W'($urandom_range(0, 3));
            a_f   = FLOW_ID_W'($urandom_range(0, 3));
            drive_cycle(($urandom_range(0, 31) == 0), nf_id,
                        ($urandom_range(0, 9) < 6), e_f, $urandom, 16'($urandom),
                        ($urandom_range(0, 9) < 4), s_f,
                        ($urandom_range(0, 9) < 3), a_f, IDX_W'($urandom_range(0, 15)));
        end

        // 6: reset between an enqueue request and its response
        init_flow(3'd6);
        enq_req_val = 1'b1; enq_req_flowid = 3'd6; enq_req_addr = 32'h6000; enq_req_len = 16'd6;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        enq_req_val = 1'b0;
        check("t6_enq_val", enq_resp_val, 1'b0);
        check("t6_send_val", send_resp_val, 1'b0);
        rst = 1'b0;
        model_clear_all();
        for (int f = 0; f < FLOW_CNT; f++) begin
            snd(FLOW_ID_W'(f));
            check("t6_empty", send_resp_empty, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
